// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_pkg                                                       |
// | Brief  : Shared types and constants for the multi-port register file      |
// |          (regfile_mp) and its busy scoreboard (regfile_scoreboard).         |
// | Rev    : 1.0  initial multi-port release                                   |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  // Default geometry. The modules take these as parameter defaults so the
  // shared addr_t/data_t types describe the standard 32 x 32 integer file.
  localparam int RF_ADDRESS_WIDTH = 5;
  localparam int RF_DATA_WIDTH    = 32;

  // x0 is hard-wired to zero and never holds a busy producer.
  localparam int ZERO_REG = 0;

  typedef logic [RF_ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [RF_DATA_WIDTH-1:0]    data_t;

  // Clear sequencer: INIT sweeps zeros through the array, RUN is normal use.
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_scoreboard                                                |
// | Brief  : Per-register busy bits for hazard detection. An issued producer   |
// |          sets busy[issue_rd]; any enabled write clears busy[wa]. When both |
// |          hit one register in the same cycle the new producer wins.          |
// | Ports  : clk, rst          clock / synchronous active-high reset           |
// |          we, wa            write enables and packed write addresses        |
// |          issue_valid/_rd   issued instruction and its destination          |
// |          ra                packed read addresses                            |
// |          rbusy             registered busy bit per read port               |
// | Rev    : 1.0  initial multi-port release                                   |
// +----------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WRITE-1:0]             we,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wa,
  input  logic                             issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]         issue_rd,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  ra,
  output logic [NUM_READ-1:0]              rbusy
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears are applied first and the issue set last, so a producer issued in
  // the same cycle as the retiring write keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (we[w]) begin
        busy_d[wa[w*AW +: AW]] = 1'b0;
      end
    end
    if (issue_valid && (issue_rd != ZERO_ADDR)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookup is on the registered bits only: a clear in this cycle becomes
  // visible to the hazard unit on the next cycle.
  always_comb begin
    rbusy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      rbusy[p] = busy_q[ra[p*AW +: AW]];
    end
  end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_mp                                                        |
// | Brief  : Parametrised multi-port integer register file with same-cycle    |
// |          write-to-read bypass, busy scoreboard and a reset-driven clear     |
// |          sweep that zeroes x1..x(DEPTH-1) before the file is usable.        |
// | Ports  : clk, rst          clock / synchronous active-high reset           |
// |          we, wa, wd        per-port write enable, address, data (packed)   |
// |          ra, rd            per-port read address / combinational data      |
// |          rbusy             busy bit of the register addressed by ra[p]     |
// |          issue_valid/_rd   issued instruction that will write issue_rd     |
// |          ready             clear sweep finished, file usable               |
// |          a0                stored contents of DEBUG_REG                     |
// | Rev    : 1.0  initial multi-port release                                   |
// +----------------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 1,
  parameter int BYPASS        = 1,
  parameter int DEBUG_REG     = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_WRITE-1:0]               we,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wd,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]     rd,
  output logic [NUM_READ-1:0]                rbusy,
  input  logic                               issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]           issue_rd,
  output logic                               ready,
  output logic [DATA_WIDTH-1:0]              a0
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  localparam logic [AW-1:0] ZERO_ADDR  = AW'(ZERO_REG);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEBUG_ADDR = AW'(DEBUG_REG);

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  rf_state_t     state_q;
  rf_state_t     state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic          run;

  assign run = (state_q == RF_RUN);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_INIT: begin
        ptr_d = ptr_q + AW'(1);
        // The last register is zeroed on this edge; usable from the next one.
        if (ptr_q == LAST_ADDR) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
    endcase
  end

  // Reset restarts the sweep at x1 from any state, including mid-sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      ptr_q   <= FIRST_ADDR;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Port gating: writes and issues are ignored until the sweep has finished.
  // --------------------------------------------------------------------------
  logic [NUM_WRITE-1:0] we_run;
  logic                 issue_run;

  assign we_run    = run ? we : '0;
  assign issue_run = run & issue_valid;

  // --------------------------------------------------------------------------
  // Storage. Entry 0 exists but is never written and never read out.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (!run) begin
      mem_d[ptr_q] = '0;
    end else begin
      // Ascending port order: the highest-numbered port wins a collision.
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (we_run[w] && (wa[w*AW +: AW] != ZERO_ADDR)) begin
          mem_d[wa[w*AW +: AW]] = wd[w*DW +: DW];
        end
      end
    end
  end

  // Contents need no reset: the sweep zeroes every architectural register
  // before ready rises.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // --------------------------------------------------------------------------
  // Read ports with optional same-cycle bypass
  // --------------------------------------------------------------------------
  always_comb begin
    rd = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (run && (ra[p*AW +: AW] != ZERO_ADDR)) begin
        rd[p*DW +: DW] = mem_q[ra[p*AW +: AW]];
        if (BYPASS != 0) begin
          // Later ports override earlier ones, matching the write priority.
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (we_run[w] && (wa[w*AW +: AW] == ra[p*AW +: AW])) begin
              rd[p*DW +: DW] = wd[w*DW +: DW];
            end
          end
        end
      end
    end
  end

  // Debug tap shows committed state only, never bypassed data.
  assign a0    = run ? mem_q[DEBUG_ADDR] : '0;
  assign ready = run;

  // --------------------------------------------------------------------------
  // Busy scoreboard
  // --------------------------------------------------------------------------
  logic [NUM_READ-1:0] busy_lookup;

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .NUM_WRITE     (NUM_WRITE)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .we          (we_run),
    .wa          (wa),
    .issue_valid (issue_run),
    .issue_rd    (issue_rd),
    .ra          (ra),
    .rbusy       (busy_lookup)
  );

  assign rbusy = run ? busy_lookup : '0;

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : tb_regfile_mp                                                     |
// | Brief  : Self-checking bench for regfile_mp against a behavioural model.   |
// | Rev    : 1.0  initial multi-port release                                   |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: two read, two write ports, bypass enabled
  logic             rst;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rbusy;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             ready;
  logic [DW-1:0]    a0;

  // Second DUT: single ports, bypass disabled
  logic [0:0]    nb_we;
  logic [AW-1:0] nb_wa;
  logic [DW-1:0] nb_wd;
  logic [AW-1:0] nb_ra;
  logic [DW-1:0] nb_rd;
  logic [0:0]    nb_rbusy;
  logic          nb_issue_valid;
  logic [AW-1:0] nb_issue_rd;
  logic          nb_ready;
  logic [DW-1:0] nb_a0;

  regfile_mp #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
    .BYPASS(1), .DEBUG_REG(10)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rbusy(rbusy), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .ready(ready), .a0(a0)
  );

  regfile_mp #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(1), .NUM_WRITE(1),
    .BYPASS(0), .DEBUG_REG(10)
  ) dut_nb (
    .clk(clk), .rst(rst), .we(nb_we), .wa(nb_wa), .wd(nb_wd), .ra(nb_ra),
    .rd(nb_rd), .rbusy(nb_rbusy), .issue_valid(nb_issue_valid),
    .issue_rd(nb_issue_rd), .ready(nb_ready), .a0(nb_a0)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model of the main DUT ----------------
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_init = 1'b1;
  int            m_left = 0;

  // Applied once per rising edge with the inputs that the edge samples.
  function automatic void model_update();
    if (rst) begin
      m_init = 1'b1;
      m_left = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (m_init) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_init = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (we[w] && wa[w*AW +: AW] != 0) m_mem[wa[w*AW +: AW]] = wd[w*DW +: DW];
      end
      for (int w = 0; w < NW; w++) begin
        if (we[w]) m_busy[wa[w*AW +: AW]] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int p);
    logic [AW-1:0] a;
    a = ra[p*AW +: AW];
    if (m_init || a == 0) return '0;
    for (int w = NW - 1; w >= 0; w--) begin
      if (we[w] && wa[w*AW +: AW] == a) return wd[w*DW +: DW];
    end
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int p);
    if (m_init) return 1'b0;
    return m_busy[ra[p*AW +: AW]];
  endfunction

  function automatic logic [DW-1:0] exp_a0();
    if (m_init) return '0;
    return m_mem[10];
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = '0; issue_valid = 1'b0; nb_we = '0; nb_issue_valid = 1'b0;
  endtask

  // Walks the clear sweep with garbage on every input to show it is ignored.
  task automatic run_sweep(output int cnt);
    cnt = 0;
    forever begin
      we = NW'($urandom); wa = (NW*AW)'($urandom); wd = {$urandom, $urandom};
      ra = (NR*AW)'($urandom); issue_valid = 1'($urandom); issue_rd = AW'($urandom);
      @(negedge clk);
      if (ready !== 1'b0 || cnt >= 100) break;
      checks++;
      if (rd !== '0) begin
        failures++; $display("FAIL sweep_rd cycle %0d: got %h want 0", cnt, rd);
      end
      checks++;
      if (rbusy !== '0) begin
        failures++; $display("FAIL sweep_rbusy cycle %0d: got %b want 0", cnt, rbusy);
      end
      checks++;
      if (a0 !== '0) begin
        failures++; $display("FAIL sweep_a0 cycle %0d: got %h want 0", cnt, a0);
      end
      cnt++;
      step();
    end
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int cnt;
    idle(); ra = '0; wa = '0; wd = '0; issue_rd = '0;
    nb_wa = '0; nb_wd = '0; nb_ra = '0; nb_issue_rd = '0;
    rst = 1'b1; step(); step(); rst = 1'b0;
    run_sweep(cnt);
    checks++;
    if (cnt !== 31) begin
      failures++; $display("FAIL sweep_len_power_on: got %0d want 31", cnt);
    end
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEAD_BEEF};
    step(); idle();
    ra = {5'd0, 5'd5};
    @(negedge clk);
    checks++;
    if (rd[31:0] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL x5_written: got %h want deadbeef", rd[31:0]);
    end
    rst = 1'b1; step(); rst = 1'b0;
    run_sweep(cnt);
    checks++;
    if (cnt !== 31) begin
      failures++; $display("FAIL sweep_len_after_rst: got %0d want 31", cnt);
    end
    ra = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd !== '0) begin
      failures++; $display("FAIL x5_cleared: got %h want 0", rd);
    end
    checks++;
    if (a0 !== '0 || ready !== 1'b1) begin
      failures++; $display("FAIL ready_a0_after_sweep: got ready=%b a0=%h want 1/0", ready, a0);
    end
    step();
  endtask

  task automatic test_basic();
    idle();
    we = 2'b01; wa = {5'd0, 5'd10}; wd = {32'd0, 32'h0000_1234};
    step(); idle();
    @(negedge clk);
    checks++;
    if (a0 !== 32'h0000_1234) begin
      failures++; $display("FAIL a0_after_write: got %h want 00001234", a0);
    end
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFF_FFFF}; ra = {5'd10, 5'd0};
    #1;
    checks++;
    if (rd[31:0] !== '0 || rd[63:32] !== 32'h0000_1234) begin
      failures++; $display("FAIL x0_write_bypass: got %h want 00001234_00000000", rd);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (rd[31:0] !== '0) begin
      failures++; $display("FAIL x0_stays_zero: got %h want 0", rd[31:0]);
    end
    step();
  endtask

  task automatic test_bypass();
    idle();
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'h0BAD_0007};
    step(); idle();
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'hA5A5_A5A5}; ra = {5'd7, 5'd0};
    @(negedge clk);
    checks++;
    if (rd[63:32] !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL bypass_rd1: got %h want a5a5a5a5", rd[63:32]);
    end
    step(); idle();
  endtask

  task automatic test_no_bypass();
    idle();
    nb_we = 1'b1; nb_wa = 5'd7; nb_wd = 32'h0BAD_0007;
    step();
    nb_we = 1'b1; nb_wa = 5'd7; nb_wd = 32'hA5A5_A5A5; nb_ra = 5'd7;
    @(negedge clk);
    checks++;
    if (nb_rd !== 32'h0BAD_0007 || nb_ready !== 1'b1) begin
      failures++; $display("FAIL no_bypass_old_value: got rd=%h ready=%b want 0bad0007/1", nb_rd, nb_ready);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (nb_rd !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL no_bypass_stored: got %h want a5a5a5a5", nb_rd);
    end
    step();
  endtask

  task automatic test_dual_write();
    idle();
    we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'h0000_0022, 32'h0000_0011}; ra = {5'd3, 5'd3};
    @(negedge clk);
    checks++;
    if (rd !== {32'h22, 32'h22}) begin
      failures++; $display("FAIL dual_write_bypass: got %h want both 00000022", rd);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (rd !== {32'h22, 32'h22}) begin
      failures++; $display("FAIL dual_write_stored: got %h want both 00000022", rd);
    end
    step();
  endtask

  task automatic test_scoreboard();
    idle();
    ra = {5'd4, 5'd4}; issue_valid = 1'b1; issue_rd = 5'd4;
    @(negedge clk);
    checks++;
    if (rbusy !== 2'b00) begin
      failures++; $display("FAIL busy_before_issue: got %b want 00", rbusy);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (rbusy !== 2'b11) begin
      failures++; $display("FAIL busy_after_issue: got %b want 11", rbusy);
    end
    issue_valid = 1'b1; issue_rd = 5'd4; we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'h44};
    step(); idle();
    @(negedge clk);
    checks++;
    if (rbusy !== 2'b11) begin
      failures++; $display("FAIL busy_issue_and_write: got %b want 11", rbusy);
    end
    we = 2'b10; wa = {5'd4, 5'd0}; wd = {32'h45, 32'd0};
    #1;
    checks++;
    if (rbusy !== 2'b11) begin
      failures++; $display("FAIL busy_same_cycle_clear: got %b want 11", rbusy);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (rbusy !== 2'b00) begin
      failures++; $display("FAIL busy_cleared: got %b want 00", rbusy);
    end
    issue_valid = 1'b1; issue_rd = 5'd0; ra = {5'd0, 5'd0};
    step(); idle();
    @(negedge clk);
    checks++;
    if (rbusy !== 2'b00) begin
      failures++; $display("FAIL busy_x0: got %b want 00", rbusy);
    end
    step();
  endtask

  task automatic test_mid_sweep_reset();
    int cnt;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step(); idle();
    ra = {5'd9, 5'd9};
    @(negedge clk);
    checks++;
    if (rbusy !== 2'b11) begin
      failures++; $display("FAIL busy_x9_set: got %b want 11", rbusy);
    end
    rst = 1'b1; step(); rst = 1'b0;
    repeat (15) step();
    rst = 1'b1; step(); rst = 1'b0;
    run_sweep(cnt);
    checks++;
    if (cnt !== 31) begin
      failures++; $display("FAIL sweep_len_mid_reset: got %0d want 31", cnt);
    end
    step();
    for (int a = 0; a < DEPTH; a += 2) begin
      ra = {AW'(a + 1), AW'(a)};
      @(negedge clk);
      checks++;
      if (rbusy !== 2'b00) begin
        failures++; $display("FAIL busy_clear_x%0d: got %b want 00", a, rbusy);
      end
      step();
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      we = NW'($urandom);
      for (int w = 0; w < NW; w++) begin
        wa[w*AW +: AW] = AW'($urandom_range(0, 11));
        wd[w*DW +: DW] = $urandom;
      end
      for (int p = 0; p < NR; p++) ra[p*AW +: AW] = AW'($urandom_range(0, 11));
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = AW'($urandom_range(0, 11));
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rd[p*DW +: DW] !== exp_rd(p)) begin
          failures++; $display("FAIL rand_rd%0d iter %0d: got %h want %h", p, i, rd[p*DW +: DW], exp_rd(p));
        end
        checks++;
        if (rbusy[p] !== exp_busy(p)) begin
          failures++; $display("FAIL rand_rbusy%0d iter %0d: got %b want %b", p, i, rbusy[p], exp_busy(p));
        end
      end
      checks++;
      if (a0 !== exp_a0() || ready !== !m_init) begin
        failures++; $display("FAIL rand_a0_ready iter %0d: got %h/%b want %h/%b", i, a0, ready, exp_a0(), !m_init);
      end
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_bypass();
    test_no_bypass();
    test_dual_write();
    test_scoreboard();
    test_mid_sweep_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core; next generation of the single-write, two-read register file.
- Adds configurable read/write port counts, same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a reset-driven clear sequencer.
- Sits in decode: read ports feed operand muxes; write ports come from writeback; issue/busy signals feed the hazard unit.

Parameters:
- ADDRESS_WIDTH, 5, register index width; DEPTH = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register data width
- NUM_READ, 2, read ports (1..4)
- NUM_WRITE, 1, write ports (1..2)
- BYPASS, 1, 1 = a read returns the same-cycle write data; 0 = the read returns the stored value
- DEBUG_REG, 10, index driven on debug output a0

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- we  in  NUM_WRITE  per-port write enable
- wa  in  NUM_WRITE*ADDRESS_WIDTH  write addresses, port p at bits [p*AW +: AW]
- wd  in  NUM_WRITE*DATA_WIDTH  write data, packed the same way
- ra  in  NUM_READ*ADDRESS_WIDTH  read addresses
- rd  out  NUM_READ*DATA_WIDTH  read data, combinational
- rbusy  out  NUM_READ  busy bit of the register addressed by ra[p]
- issue_valid  in  1  instruction issued that will write issue_rd
- issue_rd  in  ADDRESS_WIDTH  destination of the issued instruction
- ready  out  1  high when the clear sweep is done and the file is usable
- a0  out  DATA_WIDTH  contents of DEBUG_REG (debug)

Behaviour:
- States are INIT and RUN.
- rst (sampled at posedge) forces INIT, sets clear pointer = 1, clears all busy bits and drops ready next cycle. This applies from any state, including mid-sweep; a mid-sweep reset restarts the sweep at 1.
- INIT:
  - Each cycle writes 0 to reg[ptr] and increments ptr.
  - When ptr == DEPTH-1 is written, the next state is RUN.
  - Sweep length is DEPTH-1 cycles after rst deasserts (31 by default).
  - ready = 0. we, issue_valid and reads are ignored; rd = 0, rbusy = 0, a0 = 0.
- RUN: ready = 1.
- Writes:
  - Posedge write when we[p] && wa[p] != 0.
  - x0 is never written and always reads 0.
  - If both ports target the same non-zero address in one cycle, port NUM_WRITE-1 wins.
- Reads:
  - rd[p] = 0 if ra[p] == 0.
  - Otherwise, if BYPASS and some enabled write port has wa == ra[p] this cycle, rd[p] = wd of the highest such port.
  - Otherwise rd[p] = stored value.
  - a0 shows the stored value with no bypass.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets busy[issue_rd] at posedge.
  - Any enabled write to address a clears busy[a].
  - If issue and write hit the same address in one cycle, busy ends up set (the new producer wins).
  - busy[0] is constantly 0.
  - rbusy[p] = busy[ra[p]] registered state; there is no bypass of a same-cycle clear. The hazard unit sees the clear one cycle later.
- Reset values:
  - ready = 0; rbusy = 0; rd = 0 and a0 = 0 until the sweep ends.
  - Register contents after the sweep: all 0.
- Width rules:
  - All addresses are taken modulo DEPTH; no out-of-range case exists.
  - Data is stored unmodified; no sign handling.

Decomposition:
- Shared package regfile_pkg holds:
  - localparam types addr_t and data_t derived from the parameters
  - state enum rf_state_t {RF_INIT, RF_RUN}
  - ZERO_REG = 0
- One sub-module, regfile_scoreboard: busy-bit array with issue set / write clear and per-port lookup.
- Storage, bypass muxing and the clear FSM stay in regfile_mp.

Test Plan:
- Clear sweep: assert rst 1 cycle after writing 0xDEAD_BEEF to x5 → ready stays low exactly 31 cycles, then x5 reads 0 and a0 = 0.
- Basic write/read: RUN, write x10 = 0x0000_1234 → a0 = 0x1234 the next cycle. A write to x0 of 0xFFFF_FFFF leaves rd = 0 for ra = 0.
- Bypass: BYPASS = 1, we = 1, wa = 7, wd = 0xA5A5_A5A5, ra[1] = 7 in the same cycle → rd[1] = 0xA5A5_A5A5 combinationally. With BYPASS = 0 → old value.
- Dual-write conflict: NUM_WRITE = 2, both ports write x3 with 0x11 and 0x22 → x3 = 0x22; a read of x3 in that cycle (BYPASS = 1) = 0x22.
- Scoreboard: issue x4 → rbusy for ra = 4 is high next cycle. Issue x4 and write x4 in the same cycle → stays busy. A later write to x4 alone → rbusy low the following cycle.
- Reset mid-sweep: assert rst at sweep cycle 15 → sweep restarts and ready rises 31 cycles after rst deasserts; busy bits are all 0.
